// File: rtl/pkt_desc_queue_ctrl.sv
// Packet-descriptor queue controller.
// Sequences an external 1R1W block RAM (1-cycle registered read) as a FIFO and
// hides the read latency behind a 2-entry output stage, so the consumer sees a
// first-word-fall-through valid/ready interface that can pop one descriptor per clock.

package pkt_desc_queue_ctrl_pkg;
    typedef struct packed {
        logic [11:0] buf_addr;
        logic [13:0] pkt_len;
        logic [5:0]  port;
    } pkt_desc_type;
endpackage

module pkt_desc_queue_ctrl
    import pkt_desc_queue_ctrl_pkg::*;
#(
    parameter int DEPTH_NBITS = 4,
    parameter int DEPTH       = 1 << DEPTH_NBITS,
    parameter int AFULL_LVL   = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  pkt_desc_type             push_desc,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output pkt_desc_type             pop_desc,
    output logic                     ram_wr,
    output logic [DEPTH_NBITS-1:0]   ram_waddr,
    output pkt_desc_type             ram_din,
    output logic [DEPTH_NBITS-1:0]   ram_raddr,
    input  pkt_desc_type             ram_dout,
    output logic [DEPTH_NBITS+1:0]   count,
    output logic                     afull
);

    localparam logic [DEPTH_NBITS:0] DEPTH_C = (DEPTH_NBITS+1)'(DEPTH);
    localparam logic [DEPTH_NBITS:0] AFULL_C = (DEPTH_NBITS+1)'(AFULL_LVL);

    logic [DEPTH_NBITS-1:0] wptr;
    logic [DEPTH_NBITS-1:0] rptr;
    logic [DEPTH_NBITS:0]   ram_cnt;
    logic [DEPTH_NBITS:0]   ram_cnt_next;
    logic                   inflight;
    logic [1:0]             stage_cnt;
    pkt_desc_type           stage_head;
    pkt_desc_type           stage_tail;

    logic                   push_fire;
    logic                   pop_fire;
    logic                   rd_issue;
    logic                   stage_wr;
    logic [2:0]             stage_occ;

    // Producer side: a flush cycle refuses pushes so nothing lands in the RAM mid-clear.
    assign push_ready = !flush && (ram_cnt < DEPTH_C);
    assign push_fire  = push_valid && push_ready;

    assign ram_wr     = push_fire;
    assign ram_waddr  = wptr;
    assign ram_din    = push_desc;
    assign ram_raddr  = rptr;

    // Consumer side: the stage head is presented directly.
    assign pop_valid  = (stage_cnt != 2'd0);
    assign pop_desc   = stage_head;
    assign pop_fire   = pop_valid && pop_ready;

    // Issue a read only when the stage is guaranteed a free slot for the returning word,
    // counting the one already in flight and the one leaving this cycle.
    assign stage_occ  = {1'b0, stage_cnt} + {2'b00, inflight};
    assign rd_issue   = !flush && (ram_cnt != '0) && (stage_occ < (3'd2 + {2'b00, pop_fire}));

    // Returning RAM data is dropped during a flush so a pre-flush read cannot resurface.
    assign stage_wr   = inflight && !flush;

    assign count = (DEPTH_NBITS+2)'(ram_cnt) + (DEPTH_NBITS+2)'(inflight)
                 + (DEPTH_NBITS+2)'(stage_cnt);

    // Next RAM occupancy, shared by the counter and the almost-full register.
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        ram_cnt_next = ram_cnt;
        if (flush) begin
            ram_cnt_next = '0;
        end else begin
            if (push_fire) ram_cnt_next = ram_cnt_next + (DEPTH_NBITS+1)'(1);
            if (rd_issue)  ram_cnt_next = ram_cnt_next - (DEPTH_NBITS+1)'(1);
        end
    end

    // Pointers, RAM occupancy, read-in-flight flag and almost-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            afull    <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            afull    <= 1'b0;
        end else begin
            if (push_fire) wptr <= wptr + DEPTH_NBITS'(1);
            if (rd_issue)  rptr <= rptr + DEPTH_NBITS'(1);
            ram_cnt  <= ram_cnt_next;
            inflight <= rd_issue;
            afull    <= (ram_cnt_next >= AFULL_C);
        end
    end

    // Output stage occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cnt <= 2'd0;
        end else if (flush) begin
            stage_cnt <= 2'd0;
        end else begin
            case ({stage_wr, pop_fire})
                2'b10:   stage_cnt <= stage_cnt + 2'd1;
                2'b01:   stage_cnt <= stage_cnt - 2'd1;
                default: stage_cnt <= stage_cnt;
            endcase
        end
    end

    // Output stage data: in-order 2-entry shift, head always holds the oldest descriptor.
    // NOTE: data registers carry no reset; stage_cnt alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (pop_fire) begin
            if (stage_cnt == 2'd2) begin
                stage_head <= stage_tail;
                if (stage_wr) stage_tail <= ram_dout;
            end else if (stage_wr) begin
                stage_head <= ram_dout;
            end
        end else if (stage_wr) begin
            if (stage_cnt == 2'd0) stage_head <= ram_dout;
            else                   stage_tail <= ram_dout;
        end
    end

endmodule
